uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 109 ++++++++++
 tb/tb_uart_rx.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-receive bundle between the line/tick source and the uart_rx core.
// The master drives the line and the sample tick; the slave returns the received data and status.
interface uart_rx_if;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err, busy
  );

  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: centre-samples DBIT data bits, LSB first.
// Stop-bit length is set by SB_TICK; framing errors are flagged, and the frame is still delivered.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [2:0]  LAST_BIT  = 3'(DBIT - 1);
  // While in STOP, {n, s} acts as one 7-bit counter, so stop lengths above 16 ticks fit.
  localparam logic [6:0]  STOP_LAST = 7'(SB_TICK - 1);
  localparam int unsigned JUSTIFY   = 8 - DBIT;

  state_t     state_r;
  logic [3:0] s_r;
  logic [2:0] n_r;
  logic [7:0] b_r;
  logic [7:0] dout_r;
  logic       done_r;
  logic       ferr_r;
  logic       busy_r;

  // Receive FSM: state, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      s_r     <= 4'd0;
      n_r     <= 3'd0;
      b_r     <= 8'd0;
      dout_r  <= 8'd0;
      done_r  <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!bus.rx) begin
            state_r <= START;
            s_r     <= 4'd0;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s_r == 4'd7) begin
              s_r <= 4'd0;
              if (!bus.rx) begin
                state_r <= DATA;
                n_r     <= 3'd0;
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              s_r <= s_r + 4'd1;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s_r == 4'd15) begin
              s_r <= 4'd0;
              b_r <= {bus.rx, b_r[7:1]};
              if (n_r == LAST_BIT) begin
                state_r <= STOP;
                n_r     <= 3'd0;
              end else begin
                n_r <= n_r + 3'd1;
              end
            end else begin
              s_r <= s_r + 4'd1;
            end
          end
        end
        STOP: begin
          if (bus.s_tick) begin
            if ({n_r, s_r} == STOP_LAST) begin
              state_r <= IDLE;
              s_r     <= 4'd0;
              n_r     <= 3'd0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              dout_r  <= b_r >> JUSTIFY;
              ferr_r  <= ~bus.rx;
            end else begin
              {n_r, s_r} <= {n_r, s_r} + 7'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          s_r     <= 4'd0;
          n_r     <= 3'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout         = dout_r;
  assign bus.rx_done_tick = done_r;
  assign bus.frame_err    = ferr_r;
  assign bus.busy         = busy_r;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance and a 7-bit/2-stop instance, s_tick every 4 clk.
// Expected frames are queued when stimulus is sent and popped on each rx_done_tick.
module tb_uart_rx;
  typedef struct {
    logic [7:0] d;
    logic       fe;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx7 = 1'b1;
  logic [1:0] div = 2'd0;
  int         tick_cnt = 0;
  int         checks = 0;
  int         errors = 0;
  int         pulses8 = 0;
  int         pulses7 = 0;
  int         fall8 = 0;
  int         fall7 = 0;
  exp_t       q8[$];
  exp_t       q7[$];
  exp_t       e8;
  exp_t       e7;

  uart_rx_if b8();
  uart_rx_if b7();
  assign b8.s_tick = s_tick;
  assign b8.rx     = rx8;
  assign b7.s_tick = s_tick;
  assign b7.rx     = rx7;

  uart_rx #(.DBIT(8), .SB_TICK(16)) u8 (.clk(clk), .rst(rst), .bus(b8));
  uart_rx #(.DBIT(7), .SB_TICK(32)) u7 (.clk(clk), .rst(rst), .bus(b7));

  always #5 clk = ~clk;

  // Sample tick generator: one clk in four, counted for latency checks.
  always @(negedge clk) begin
    div = div + 2'd1;
    s_tick = (div == 2'd0);
    if (div == 2'd0) tick_cnt = tick_cnt + 1;
  end

  // Scoreboard for the 8N1 instance.
  always @(negedge clk) begin
    if (rst && b8.rx_done_tick) begin
      pulses8 = pulses8 + 1;
      checks = checks + 1;
      if (q8.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse8: got pulse dout=%h at tick %0d, required no pulse", b8.dout, tick_cnt);
      end else begin
        e8 = q8.pop_front();
        if (b8.dout !== e8.d) begin
          errors = errors + 1;
          $display("FAIL dout8: got %h, required %h", b8.dout, e8.d);
        end
        checks = checks + 1;
        if (b8.frame_err !== e8.fe) begin
          errors = errors + 1;
          $display("FAIL frame_err8: got %b, required %b", b8.frame_err, e8.fe);
        end
        if (e8.lat >= 0) begin
          checks = checks + 1;
          if (tick_cnt - fall8 != e8.lat) begin
            errors = errors + 1;
            $display("FAIL latency8: got %0d ticks, required %0d", tick_cnt - fall8, e8.lat);
          end
        end
      end
    end
  end

  // Scoreboard for the 7-bit, two-stop-bit instance.
  always @(negedge clk) begin
    if (rst && b7.rx_done_tick) begin
      pulses7 = pulses7 + 1;
      checks = checks + 1;
      if (q7.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse7: got pulse dout=%h at tick %0d, required no pulse", b7.dout, tick_cnt);
      end else begin
        e7 = q7.pop_front();
        if (b7.dout !== e7.d) begin
          errors = errors + 1;
          $display("FAIL dout7: got %h, required %h", b7.dout, e7.d);
        end
        checks = checks + 1;
        if (b7.frame_err !== e7.fe) begin
          errors = errors + 1;
          $display("FAIL frame_err7: got %b, required %b", b7.frame_err, e7.fe);
        end
        if (e7.lat >= 0) begin
          checks = checks + 1;
          if (tick_cnt - fall7 != e7.lat) begin
            errors = errors + 1;
            $display("FAIL latency7: got %0d ticks, required %0d", tick_cnt - fall7, e7.lat);
          end
        end
      end
    end
  end

  task automatic push8(input logic [7:0] d, input logic fe, input int lat);
    exp_t e;
    e.d = d; e.fe = fe; e.lat = lat;
    q8.push_back(e);
  endtask

  task automatic push7(input logic [7:0] d, input logic fe, input int lat);
    exp_t e;
    e.d = d; e.fe = fe; e.lat = lat;
    q7.push_back(e);
  endtask

  // Waits for n s_tick cycles, then returns on the following negedge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 7) rx7 = v;
    else rx8 = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                            input int stop_ticks, input logic stop_val);
    drive(which, 1'b0);
    if (which == 7) fall7 = tick_cnt;
    else fall8 = tick_cnt;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      drive(which, data[i]);
      wait_ticks(16);
    end
    drive(which, stop_val);
    wait_ticks(stop_ticks);
    drive(which, 1'b1);
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (((which == 7) ? q7.size() : q8.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (((which == 7) ? q7.size() : q8.size()) != 0) begin
      errors = errors + 1;
      $display("FAIL drain%0d: got %0d frames outstanding after timeout, required 0", which,
               (which == 7) ? q7.size() : q8.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks = checks + 4;
    if (b8.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h, required 00", b8.dout); end
    if (b8.rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", b8.rx_done_tick); end
    if (b8.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, required 0", b8.frame_err); end
    if (b8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", b8.busy); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks = checks + 2;
    if (b8.busy !== 1'b0 || b7.busy !== 1'b0) begin
      errors++; $display("FAIL release_busy: got %b/%b, required 0/0", b8.busy, b7.busy);
    end
    if (pulses8 + pulses7 != 0) begin
      errors++; $display("FAIL release_pulse: got %0d pulses, required 0", pulses8 + pulses7);
    end
  endtask

  task automatic test_basic;
    int p0;
    p0 = pulses8;
    wait_ticks(1);
    push8(8'h55, 1'b0, 152);
    send_frame(8, 8'h55, 8, 16, 1'b1);
    drain(8);
    checks = checks + 2;
    if (b8.busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, required 0", b8.busy); end
    if (pulses8 - p0 != 1) begin errors++; $display("FAIL basic_pulses: got %0d, required 1", pulses8 - p0); end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulses8;
    wait_ticks(1);
    push8(8'hA3, 1'b0, 152);
    push8(8'h0F, 1'b0, 152);
    send_frame(8, 8'hA3, 8, 16, 1'b1);
    send_frame(8, 8'h0F, 8, 16, 1'b1);
    drain(8);
    checks = checks + 1;
    if (pulses8 - p0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d, required 2", pulses8 - p0); end
  endtask

  task automatic test_glitch;
    int p0;
    int bc;
    p0 = pulses8;
    bc = 0;
    wait_ticks(1);
    rx8 = 1'b0;
    repeat (20) begin @(negedge clk); if (b8.busy === 1'b1) bc++; end
    rx8 = 1'b1;
    repeat (60) begin @(negedge clk); if (b8.busy === 1'b1) bc++; end
    checks = checks + 3;
    if (bc < 20 || bc > 32) begin errors++; $display("FAIL glitch_busy: got %0d clk busy, required 20..32", bc); end
    if (pulses8 != p0) begin errors++; $display("FAIL glitch_pulse: got %0d pulses, required 0", pulses8 - p0); end
    if (b8.busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy %b, required 0", b8.busy); end
  endtask

  task automatic test_frame_err;
    int p0;
    p0 = pulses8;
    wait_ticks(1);
    push8(8'hC6, 1'b1, 152);
    push8(8'h12, 1'b0, 152);
    send_frame(8, 8'hC6, 8, 12, 1'b0);
    wait_ticks(20);
    send_frame(8, 8'h12, 8, 16, 1'b1);
    drain(8);
    checks = checks + 1;
    if (pulses8 - p0 != 2) begin errors++; $display("FAIL ferr_pulses: got %0d, required 2", pulses8 - p0); end
  endtask

  task automatic test_break;
    int p0;
    p0 = pulses8;
    wait_ticks(1);
    push8(8'h00, 1'b1, -1);
    push8(8'h00, 1'b1, -1);
    rx8 = 1'b0;
    wait_ticks(308);
    rx8 = 1'b1;
    wait_ticks(16);
    drain(8);
    checks = checks + 2;
    if (pulses8 - p0 != 2) begin errors++; $display("FAIL break_pulses: got %0d, required 2", pulses8 - p0); end
    if (b8.busy !== 1'b0) begin errors++; $display("FAIL break_idle: got busy %b, required 0", b8.busy); end
  endtask

  task automatic test_reset_mid;
    int p0;
    p0 = pulses8;
    wait_ticks(1);
    rx8 = 1'b0;
    wait_ticks(16);
    rx8 = 1'b1;
    wait_ticks(64);
    checks = checks + 1;
    if (b8.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b, required 1", b8.busy); end
    rst = 1'b0;
    @(negedge clk);
    checks = checks + 3;
    if (b8.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", b8.busy); end
    if (b8.dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h, required 00", b8.dout); end
    if (b8.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b, required 0", b8.frame_err); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_ticks(32);
    checks = checks + 2;
    if (b8.busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got busy %b, required 0", b8.busy); end
    if (pulses8 != p0) begin errors++; $display("FAIL midrst_nopulse: got %0d pulses, required 0", pulses8 - p0); end
    push8(8'h3C, 1'b0, 152);
    send_frame(8, 8'h3C, 8, 16, 1'b1);
    drain(8);
    checks = checks + 1;
    if (pulses8 - p0 != 1) begin errors++; $display("FAIL midrst_pulses: got %0d, required 1", pulses8 - p0); end
  endtask

  task automatic test_dbit7;
    int p0;
    p0 = pulses7;
    wait_ticks(1);
    push7(8'h5A, 1'b0, 152);
    send_frame(7, 8'h5A, 7, 32, 1'b1);
    drain(7);
    checks = checks + 2;
    if (pulses7 - p0 != 1) begin errors++; $display("FAIL dbit7_pulses: got %0d, required 1", pulses7 - p0); end
    if (b7.busy !== 1'b0) begin errors++; $display("FAIL dbit7_idle: got busy %b, required 0", b7.busy); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_break;
    test_reset_mid;
    test_dbit7;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
